// File: rtl/dp_mem.sv
// True dual-port synchronous RAM, read-first, registered reads; reset clears every word.
// Latency 1 cycle (2 with DP_MEM_OUTREG_EN); no backpressure, both ports accept an access every cycle.
// Same-address double write on one edge keeps port A's data and drops port B's.
module dp_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data_a,
    input  logic [ADDR_WIDTH-1:0] in_addr_a,
    input  logic                  en_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] out_data_a,
    input  logic [DATA_WIDTH-1:0] in_data_b,
    input  logic [ADDR_WIDTH-1:0] in_addr_b,
    input  logic                  en_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] out_data_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] memory   [DEPTH];
    logic [DATA_WIDTH-1:0] memory_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_a_d, rd_a_q;
    logic [DATA_WIDTH-1:0] rd_b_d, rd_b_q;

    always_comb begin
        memory_d = memory;
        rd_a_d   = rd_a_q;
        rd_b_d   = rd_b_q;
        // Reads sample the pre-write contents, giving read-first on both ports.
        if (en_a) rd_a_d = memory[in_addr_a];
        if (en_b) rd_b_d = memory[in_addr_b];
        // Port B is applied first so port A overrides it on an address collision.
        if (en_b && we_b) memory_d[in_addr_b] = in_data_b;
        if (en_a && we_a) memory_d[in_addr_a] = in_data_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memory <= '{default: '0};
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            memory <= memory_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

`ifdef DP_MEM_OUTREG_EN
    logic [DATA_WIDTH-1:0] pipe_a_d, pipe_a_q;
    logic [DATA_WIDTH-1:0] pipe_b_d, pipe_b_q;

    always_comb begin
        pipe_a_d = rd_a_q;
        pipe_b_d = rd_b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_a_q <= '0;
            pipe_b_q <= '0;
        end else begin
            pipe_a_q <= pipe_a_d;
            pipe_b_q <= pipe_b_d;
        end
    end

    assign out_data_a = pipe_a_q;
    assign out_data_b = pipe_b_q;
`else
    assign out_data_a = rd_a_q;
    assign out_data_b = rd_b_q;
`endif

endmodule

// File: tb/tb_dp_mem.sv
// Bench for dp_mem: directed scenarios plus random traffic against an array-based reference model.
module tb_dp_mem;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
`ifdef DP_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data_a = '0, in_data_b = '0;
    logic [AW-1:0] in_addr_a = '0, in_addr_b = '0;
    logic          en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [DW-1:0] out_data_a, out_data_b;

    always #5 clk = ~clk;

    dp_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_data_a(in_data_a), .in_addr_a(in_addr_a), .en_a(en_a), .we_a(we_a), .out_data_a(out_data_a),
        .in_data_b(in_data_b), .in_addr_b(in_addr_b), .en_b(en_b), .we_b(we_b), .out_data_b(out_data_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: word array plus the value each port's output should show after 1 and 2 edges.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_a1, ref_a2, ref_b1, ref_b2;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_out_a();
        return (LAT == 1) ? ref_a1 : ref_a2;
    endfunction

    function automatic logic [DW-1:0] ref_out_b();
        return (LAT == 1) ? ref_b1 : ref_b2;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_a1 = '0; ref_a2 = '0; ref_b1 = '0; ref_b2 = '0;
    endtask

    task automatic drive(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        en_a = ea; we_a = wa; in_addr_a = aa; in_data_a = da;
        en_b = eb; we_b = wb; in_addr_b = ab; in_data_b = db;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock: model the edge from the spec rules, then check both outputs at the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            ref_a2 = ref_a1;
            ref_b2 = ref_b1;
            if (en_a) ref_a1 = ref_mem[in_addr_a];
            if (en_b) ref_b1 = ref_mem[in_addr_b];
            if (en_b && we_b && !(en_a && we_a && in_addr_a == in_addr_b))
                ref_mem[in_addr_b] = in_data_b;
            if (en_a && we_a) ref_mem[in_addr_a] = in_data_a;
        end
        @(negedge clk);
        chk("out_a", out_data_a, ref_out_a());
        chk("out_b", out_data_b, ref_out_b());
    endtask

    // Called at a falling edge; asserts rst between edges with both ports busy.
    task automatic do_reset();
        drive(1'b1, 1'b1, 8'h00, 8'h77, 1'b1, 1'b1, 8'h01, 8'h66);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) chk($sformatf("rst_mem%0d", i), dut.memory[i], 8'h00);
        chk("rst_out_a", out_data_a, 8'h00);
        chk("rst_out_b", out_data_b, 8'h00);
        ref_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    initial begin
        ref_clear();
        repeat (2) @(negedge clk);
        chk("init_out_a", out_data_a, 8'h00);
        chk("init_out_b", out_data_b, 8'h00);
        chk("init_mem", dut.memory[200], 8'h00);
        rst = 1'b0;

        // Reset clear: fill 0..15 with FF, then reset between edges.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, AW'(i), 8'hFF, 1'b1, 1'b0, AW'(i), '0);
            step();
        end
        idle(); step();
        chk("fill_mem15", dut.memory[15], 8'hFF);
        do_reset();

        // Basic write then read on port A, then hold with en_a low.
        drive(1'b1, 1'b1, 8'h03, 8'h5A, 1'b0, 1'b0, '0, '0); step();
        drive(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, '0, '0); step();
        idle();
        repeat (LAT - 1) step();
        chk("basic_rd", out_data_a, 8'h5A);
        repeat (3) step();
        chk("basic_hold", out_data_a, 8'h5A);

        // Read-modify-write of addr 4, three increments.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, '0, '0); step();
            idle();
            repeat (LAT - 1) step();
            drive(1'b1, 1'b1, 8'h04, out_data_a + 8'h01, 1'b0, 1'b0, '0, '0); step();
        end
        idle(); step();
        chk("rmw_mem4", dut.memory[4], 8'h03);

        // Read-first on port A.
        drive(1'b1, 1'b1, 8'h07, 8'h11, 1'b0, 1'b0, '0, '0); step();
        drive(1'b1, 1'b1, 8'h07, 8'h22, 1'b0, 1'b0, '0, '0); step();
        idle();
        repeat (LAT - 1) step();
        chk("rdfirst_old", out_data_a, 8'h11);
        drive(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0, '0, '0); step();
        idle();
        repeat (LAT - 1) step();
        chk("rdfirst_new", out_data_a, 8'h22);

        // Cross-port collisions.
        drive(1'b1, 1'b1, 8'h09, 8'hAA, 1'b1, 1'b1, 8'h09, 8'hBB); step();
        chk("ww_mem9", dut.memory[9], 8'hAA);
        drive(1'b1, 1'b1, 8'h0A, 8'h33, 1'b1, 1'b0, 8'h0A, 8'h00); step();
        idle();
        repeat (LAT - 1) step();
        chk("wr_out_b", out_data_b, 8'h00);
        chk("wr_mem10", dut.memory[10], 8'h33);
        drive(1'b1, 1'b0, 8'h09, 8'h00, 1'b1, 1'b0, 8'h09, 8'h00); step();
        idle();
        repeat (LAT - 1) step();
        chk("rr_same", out_data_b, out_data_a);
        chk("rr_val", out_data_b, 8'hAA);

        // Full range: A writes i to addr i, B reads the trailing address.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, AW'(i), DW'(i), i > 0, 1'b0, AW'(i - 1), 8'h00);
            step();
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'hFF, 8'h00); step();
        idle();
        repeat (LAT - 1) step();
        chk("full_last", out_data_b, 8'hFF);

        // Random traffic on a narrow address window to provoke collisions, with one reset mid-run.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            drive(1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
                  1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
            step();
        end
        idle();
        repeat (LAT) step();
        for (int i = 0; i < 8; i++) chk($sformatf("final_mem%0d", i), dut.memory[i], ref_mem[i]);
        chk("final_mem100", dut.memory[100], ref_mem[100]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
